sll_seq: RTL and testbench

SLL_SEQ -- requirements
Module: sll_seq

---
 rtl/sll_seq_pkg.sv | 14 +
 rtl/sll_seq.sv | 103 ++++++++++
 tb/tb_sll_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sll_seq_pkg.sv
// Shared definitions for the sequential shift-left-logical unit:
// operand widths and the controller state encoding.
package sll_seq_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sll_seq.sv
// Iterative logical left shifter: one bit position per cycle, result held
// until the consumer takes it. All outputs come straight from flops.
module sll_seq
    import sll_seq_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [XLEN-1:0]    a_i,
    input  logic [SHAMT_W-1:0] b_i,
    input  logic               flush_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    c_o,
    output logic               busy_o
);

    state_e               r_state;
    logic [XLEN-1:0]      r_acc;
    logic [SHAMT_W-1:0]   r_cnt;
    logic                 r_valid;
    logic                 r_ready;
    logic                 r_busy;
    logic [XLEN-1:0]      r_c;

    state_e               w_state_nxt;
    logic [XLEN-1:0]      w_acc_nxt;
    logic [SHAMT_W-1:0]   w_cnt_nxt;

    // Next-state, accumulator and counter logic; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        if (flush_i) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = {XLEN{1'b0}};
            w_cnt_nxt   = {SHAMT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        w_acc_nxt   = a_i;
                        w_cnt_nxt   = b_i;
                        w_state_nxt = (b_i == {SHAMT_W{1'b0}}) ? DONE : SHIFT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                SHIFT: begin
                    w_acc_nxt = {r_acc[XLEN-2:0], 1'b0};
                    w_cnt_nxt = r_cnt - SHAMT_W'(1);
                    // A zero count here is unreachable; finish rather than wrap.
                    if (r_cnt <= SHAMT_W'(1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SHIFT;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = {XLEN{1'b0}};
                    w_cnt_nxt   = {SHAMT_W{1'b0}};
                end
            endcase
        end
    end

    // State registers plus output flops decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_acc   <= {XLEN{1'b0}};
            r_cnt   <= {SHAMT_W{1'b0}};
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_c     <= {XLEN{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_state_nxt == DONE);
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            r_c     <= (w_state_nxt == DONE) ? w_acc_nxt : {XLEN{1'b0}};
        end
    end

    assign valid_o = r_valid;
    assign ready_o = r_ready;
    assign busy_o  = r_busy;
    assign c_o     = r_c;

endmodule

// File: tb/tb_sll_seq.sv
// Directed self-checking bench for sll_seq.
module tb_sll_seq;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [4:0]  b_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] c_o;
    logic        busy_o;

    int n_tests;
    int n_fail;
    logic saw_valid;

    sll_seq dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o),
        .busy_o  (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready"}, {31'd0, ready_o}, 32'd1);
        check({tag, " valid"}, {31'd0, valid_o}, 32'd0);
        check({tag, " busy"},  {31'd0, busy_o},  32'd0);
        check({tag, " c"},     c_o,              32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_ni    = 1'b1;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        ready_i   = 1'b0;
        a_i       = 32'd0;
        b_i       = 5'd0;
        #1 rst_ni = 1'b0;
        #2;
        check_idle("reset");
        #14 rst_ni = 1'b1;

        // b=0: result the cycle after accept
        valid_i = 1'b1; a_i = 32'hDEADBEEF; b_i = 5'd0;
        tick();
        valid_i = 1'b0; a_i = 32'h0;
        check("b0 valid", {31'd0, valid_o}, 32'd1);
        check("b0 c",     c_o,              32'hDEADBEEF);
        check("b0 ready", {31'd0, ready_o}, 32'd0);
        check("b0 busy",  {31'd0, busy_o},  32'd1);
        ready_i = 1'b1;
        tick();
        check_idle("b0 ret");
        ready_i = 1'b0;

        // b=31: valid after edge N+31, inputs changed and valid_i held during SHIFT
        valid_i = 1'b1; a_i = 32'h00000001; b_i = 5'd31;
        tick();
        a_i = 32'hFFFF0000; b_i = 5'd3;
        check("b31 busy",  {31'd0, busy_o},  32'd1);
        check("b31 ready", {31'd0, ready_o}, 32'd0);
        check("b31 c0",    c_o,              32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) valid_i = 1'b0;
            tick();
            saw_valid = saw_valid | valid_o;
        end
        check("b31 early", {31'd0, saw_valid}, 32'd0);
        tick();
        check("b31 valid", {31'd0, valid_o}, 32'd1);
        check("b31 c",     c_o,              32'h80000000);
        ready_i = 1'b1;
        tick();
        check_idle("b31 ret");
        ready_i = 1'b0;

        // backpressure hold
        valid_i = 1'b1; a_i = 32'h12345678; b_i = 5'd4;
        tick();
        valid_i = 1'b0;
        tick(); tick(); tick();
        check("bp early", {31'd0, valid_o}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp c",     c_o,              32'h23456780);
            check("bp valid", {31'd0, valid_o}, 32'd1);
            check("bp ready", {31'd0, ready_o}, 32'd0);
            tick();
        end
        ready_i = 1'b1;
        tick();
        check_idle("bp ret");
        ready_i = 1'b0;

        // flush mid-SHIFT
        valid_i = 1'b1; a_i = 32'hFFFFFFFF; b_i = 5'd16;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_idle("flush");
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_valid = saw_valid | valid_o;
        end
        check("flush novalid", {31'd0, saw_valid}, 32'd0);
        check("flush ready",   {31'd0, ready_o},   32'd1);

        // flush beats valid_i in IDLE
        flush_i = 1'b1; valid_i = 1'b1; a_i = 32'h5; b_i = 5'd0;
        tick();
        check_idle("flush prio");
        flush_i = 1'b0; valid_i = 1'b0;

        // flush beats ready_i in DONE: result discarded, unit idle
        valid_i = 1'b1; a_i = 32'h0000_00A5; b_i = 5'd2;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        check("fd valid", {31'd0, valid_o}, 32'd1);
        check("fd c",     c_o,              32'h0000_0294);
        flush_i = 1'b1; ready_i = 1'b1;
        tick();
        flush_i = 1'b0; ready_i = 1'b0;
        check_idle("fd ret");

        // async reset mid-SHIFT
        valid_i = 1'b1; a_i = 32'h0000FFFF; b_i = 5'd10;
        tick();
        valid_i = 1'b0;
        tick(); tick(); tick();
        #2 rst_ni = 1'b0;
        #1;
        check_idle("arst");
        #1 rst_ni = 1'b1;
        valid_i = 1'b1; a_i = 32'h00000003; b_i = 5'd1;
        tick();
        valid_i = 1'b0;
        check("arst acc busy",  {31'd0, busy_o},  32'd1);
        check("arst acc valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("arst valid", {31'd0, valid_o}, 32'd1);
        check("arst c",     c_o,              32'h00000006);
        ready_i = 1'b1;
        tick();
        check_idle("arst ret");

        // back-to-back with valid_i held and ready_i high
        valid_i = 1'b1; a_i = 32'h0000000F; b_i = 5'd2;
        tick();
        a_i = 32'h80000001; b_i = 5'd1;
        tick();
        tick();
        check("b2b1 valid", {31'd0, valid_o}, 32'd1);
        check("b2b1 c",     c_o,              32'h0000003C);
        tick();
        check("b2b idle ready", {31'd0, ready_o}, 32'd1);
        check("b2b idle valid", {31'd0, valid_o}, 32'd0);
        tick();
        valid_i = 1'b0;
        check("b2b2 busy",  {31'd0, busy_o},  32'd1);
        check("b2b2 valid", {31'd0, valid_o}, 32'd0);
        tick();
        check("b2b2 valid1", {31'd0, valid_o}, 32'd1);
        check("b2b2 c",      c_o,              32'h00000002);
        tick();
        check_idle("b2b ret");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
